ntsc_composite_enc: RTL



---
 rtl/ntsc_composite_enc_pkg.sv | 54 +++++
 rtl/ntsc_composite_enc_qam_mod.sv | 34 +++
 rtl/ntsc_composite_enc.sv | 118 +++++++++++
 3 files changed

// File: rtl/ntsc_composite_enc_pkg.sv
// Shared levels, sine table and stage types for the NTSC encoders.
package ntsc_composite_enc_pkg;

  localparam int PH_W = 3;

  localparam logic [7:0] LVL_SYNC  = 8'd0;
  localparam logic [7:0] LVL_BLANK = 8'd60;
  localparam logic [7:0] Y_GAIN    = 8'd140;
  localparam logic [7:0] LVL_WHITE = 8'(int'(LVL_BLANK) + ((255 * int'(Y_GAIN)) >> 8));
  localparam logic [7:0] BURST_AMP = 8'd20;
  localparam logic [7:0] CLIP_LO   = 8'd16;

  // Eight-point sine, 45 degree steps, peak 64.
  function automatic logic signed [7:0] sine_lut(input logic [PH_W-1:0] ph);
    logic signed [7:0] s;
    case (ph)
      3'd0:    s = 8'sd0;
      3'd1:    s = 8'sd45;
      3'd2:    s = 8'sd64;
      3'd3:    s = 8'sd45;
      3'd4:    s = 8'sd0;
      3'd5:    s = -8'sd45;
      3'd6:    s = -8'sd64;
      default: s = -8'sd45;
    endcase
    return s;
  endfunction

  typedef struct packed {
    logic              xsync;
    logic              xblk;
    logic              burst;
    logic              kill;
    logic signed [7:0] sin;
    logic signed [7:0] cos;
    logic [15:0]       yl;
    logic signed [7:0] u;
    logic signed [7:0] v;
  } stage1_t;

  // Cleared stage 1 reads as "not sync, blanking, no burst".
  localparam stage1_t STAGE1_CLR = '{
    xsync: 1'b1, xblk: 1'b0, burst: 1'b0, kill: 1'b0,
    sin: 8'sd0, cos: 8'sd0, yl: 16'd0, u: 8'sd0, v: 8'sd0
  };

  typedef enum logic [1:0] {
    SEL_SYNC,
    SEL_BURST,
    SEL_BLANK,
    SEL_ACTIVE
  } dac_sel_e;

endpackage

// File: rtl/ntsc_composite_enc_qam_mod.sv
// Subcarrier lookup and quadrature chroma modulation.
// Lookup runs on the live phase (feeds stage 1); the multiply runs on the
// registered sin/cos/U/V coming out of stage 1.
module ntsc_qam_mod
  import ntsc_composite_enc_pkg::*;
(
  input  logic [PH_W-1:0]   ph_i,
  output logic signed [7:0] sin_o,
  output logic signed [7:0] cos_o,
  input  logic signed [7:0] sin_i,
  input  logic signed [7:0] cos_i,
  input  logic signed [7:0] u_i,
  input  logic signed [7:0] v_i,
  input  logic              kill_i,
  output logic signed [10:0] chroma_o
);

  logic [PH_W-1:0]    ph_cos;
  logic signed [15:0] prod_u;
  logic signed [15:0] prod_v;
  logic signed [16:0] sum;

  // Table lookup, signed products, arithmetic shift back to DAC scale.
  always_comb begin
    ph_cos   = ph_i + PH_W'(2);
    sin_o    = sine_lut(ph_i);
    cos_o    = sine_lut(ph_cos);
    prod_u   = 16'(u_i) * 16'(sin_i);
    prod_v   = 16'(v_i) * 16'(cos_i);
    sum      = $signed({prod_u[15], prod_u}) + $signed({prod_v[15], prod_v});
    chroma_o = kill_i ? '0 : 11'(sum >>> 7);
  end

endmodule

// File: rtl/ntsc_composite_enc.sv
// Composite encoder: two pixel-enable pipeline producing one DAC code per pixel.
module ntsc_composite_enc
  import ntsc_composite_enc_pkg::*;
#(
  parameter logic [7:0] C_SYNC_LVL  = LVL_SYNC,
  parameter logic [7:0] C_BLANK_LVL = LVL_BLANK,
  parameter logic [7:0] C_Y_GAIN    = Y_GAIN,
  parameter logic [7:0] C_BURST_AMP = BURST_AMP,
  parameter logic [7:0] C_CLIP_LO   = CLIP_LO
) (
  input  logic            CK_i,
  input  logic            XARST_i,
  input  logic            RST_i,
  input  logic            PX_CK_EE_i,
  input  logic            XSYNC_i,
  input  logic            XBLK_i,
  input  logic            CBURST_NOW_i,
  input  logic [PH_W-1:0] CPHs_i,
  input  logic            COLOR_KILL_i,
  input  logic [7:0]      Y_i,
  input  logic [7:0]      U_i,
  input  logic [7:0]      V_i,
  output logic [7:0]      DAC_o
);

  stage1_t            s1_d, s1_q;
  logic [7:0]         dac_d, dac_q;
  logic signed [7:0]  sin_lk, cos_lk;
  logic signed [10:0] chroma;
  logic [15:0]        y_prod;
  logic signed [15:0] burst_prod;
  logic [7:0]         burst_code;
  logic signed [10:0] yl_s;
  logic signed [10:0] act;
  logic signed [10:0] lo_s;
  logic [7:0]         act_code;
  dac_sel_e           sel;

  ntsc_qam_mod u_qam (
    .ph_i     (CPHs_i),
    .sin_o    (sin_lk),
    .cos_o    (cos_lk),
    .sin_i    (s1_q.sin),
    .cos_i    (s1_q.cos),
    .u_i      (s1_q.u),
    .v_i      (s1_q.v),
    .kill_i   (s1_q.kill),
    .chroma_o (chroma)
  );

  // Stage 1 next state: capture flags, trig values, scaled luma and U/V.
  always_comb begin
    y_prod = {8'd0, Y_i} * {8'd0, C_Y_GAIN};
    s1_d   = s1_q;
    if (PX_CK_EE_i) begin
      if (RST_i) begin
        s1_d = STAGE1_CLR;
      end else begin
        s1_d.xsync = XSYNC_i;
        s1_d.xblk  = XBLK_i;
        s1_d.burst = CBURST_NOW_i;
        s1_d.kill  = COLOR_KILL_i;
        s1_d.sin   = sin_lk;
        s1_d.cos   = cos_lk;
        s1_d.yl    = {8'd0, C_BLANK_LVL} + 16'(y_prod >> 8);
        s1_d.u     = $signed(U_i);
        s1_d.v     = $signed(V_i);
      end
    end
  end

  // Stage 1 register.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) s1_q <= STAGE1_CLR;
    else          s1_q <= s1_d;
  end

  // Stage 2 next state: level select with sync > burst > blank > active.
  always_comb begin
    burst_prod = 16'($signed(s1_q.sin)) * $signed(16'(C_BURST_AMP));
    burst_code = C_BLANK_LVL - 8'(burst_prod >>> 6);
    yl_s       = $signed(11'(s1_q.yl));
    act        = yl_s + chroma;
    lo_s       = $signed({3'b000, C_CLIP_LO});
    if (act < lo_s)              act_code = C_CLIP_LO;
    else if (act > 11'sd255)     act_code = 8'd255;
    else                         act_code = 8'(act);

    if (!s1_q.xsync)     sel = SEL_SYNC;
    else if (s1_q.burst) sel = SEL_BURST;
    else if (!s1_q.xblk) sel = SEL_BLANK;
    else                 sel = SEL_ACTIVE;

    dac_d = dac_q;
    if (PX_CK_EE_i) begin
      if (RST_i) begin
        dac_d = C_BLANK_LVL;
      end else begin
        case (sel)
          SEL_SYNC:   dac_d = C_SYNC_LVL;
          SEL_BURST:  dac_d = s1_q.kill ? C_BLANK_LVL : burst_code;
          SEL_BLANK:  dac_d = C_BLANK_LVL;
          SEL_ACTIVE: dac_d = act_code;
          default:    dac_d = C_BLANK_LVL;
        endcase
      end
    end
  end

  // Stage 2 register, resets to blank level.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) dac_q <= C_BLANK_LVL;
    else          dac_q <= dac_d;
  end

  assign DAC_o = dac_q;

endmodule
